// File: rtl/cache_ctrl_wb.sv
// rtl/cache_ctrl_wb.sv - direct-mapped write-back write-allocate data cache controller
//
// Sits between the core load/store port and a line-wide memory. Each access
// is latched in IDLE and resolved in COMPARE. A miss on a dirty line first
// writes the victim back (WRITEBACK), then refills the line (ALLOCATE). The
// FSM then returns to COMPARE, where the access completes as a hit.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata core request, held until cpu_ready
//   cpu_rdata, cpu_ready  load data and one-cycle completion pulse
//   mem_req/we/addr/wdata line transfer request (we=1 write-back, 0 refill)
//   mem_rdata, mem_ack    refill line and one-cycle memory completion
//   hit_cnt, miss_cnt     wrapping 16-bit performance counters
module cache_ctrl_wb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int LINES  = 16,
   parameter int WORDS  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cpu_req,
   input  logic                    cpu_we,
   input  logic [ADDR_W-1:0]       cpu_addr,
   input  logic [DATA_W-1:0]       cpu_wdata,
   output logic [DATA_W-1:0]       cpu_rdata,
   output logic                    cpu_ready,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [WORDS*DATA_W-1:0] mem_wdata,
   input  logic [WORDS*DATA_W-1:0] mem_rdata,
   input  logic                    mem_ack,
   output logic [15:0]             hit_cnt,
   output logic [15:0]             miss_cnt
);
   localparam int BO     = $clog2(DATA_W / 8);
   localparam int WO     = $clog2(WORDS);
   localparam int IX     = $clog2(LINES);
   localparam int TAG_W  = ADDR_W - IX - WO - BO;
   localparam int LINE_W = WORDS * DATA_W;

   typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_WRITEBACK, S_ALLOCATE} state_t;
   state_t state, state_nx;

   logic [LINES-1:0]  valid;
   logic [LINES-1:0]  dirty;
   logic [TAG_W-1:0]  tag_arr  [LINES];
   logic [LINE_W-1:0] data_arr [LINES];

   logic [ADDR_W-1:0] req_addr;
   logic              req_we;
   logic [DATA_W-1:0] req_wdata;
   logic              missed;   // current access already counted as a miss

   logic [TAG_W-1:0]  req_tag;
   logic [IX-1:0]     req_idx;
   logic [WO-1:0]     req_word;
   logic [LINE_W-1:0] cur_line;
   logic [DATA_W-1:0] sel_word;
   logic              hit;
   logic              unused_lsb;

   assign req_tag  = req_addr[ADDR_W-1 -: TAG_W];
   assign req_idx  = req_addr[IX+WO+BO-1 -: IX];
   assign req_word = req_addr[WO+BO-1 -: WO];
   assign cur_line = data_arr[req_idx];
   assign sel_word = cur_line[req_word*DATA_W +: DATA_W];
   assign hit      = valid[req_idx] && (tag_arr[req_idx] == req_tag);

   // Byte-offset bits select nothing inside a word.
   generate
      if (BO > 0) begin : g_lsb
         assign unused_lsb = ^req_addr[BO-1:0];
      end else begin : g_no_lsb
         assign unused_lsb = 1'b0;
      end
   endgenerate

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:      if (cpu_req) state_nx = S_COMPARE;
         S_COMPARE: begin
            if (hit)                                  state_nx = S_IDLE;
            else if (valid[req_idx] && dirty[req_idx]) state_nx = S_WRITEBACK;
            else                                      state_nx = S_ALLOCATE;
         end
         S_WRITEBACK: if (mem_ack) state_nx = S_ALLOCATE;
         S_ALLOCATE:  if (mem_ack) state_nx = S_COMPARE;
         default:     state_nx = S_IDLE;
      endcase
   end

   // Outputs decoded from registered state only; everything idles at zero,
   // which also keeps the don't-care outputs at 0 during reset.
   always_comb begin
      cpu_ready = 1'b0;
      cpu_rdata = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         S_COMPARE: begin
            if (hit) begin
               cpu_ready = 1'b1;
               cpu_rdata = sel_word;
            end
         end
         S_WRITEBACK: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {tag_arr[req_idx], req_idx, {(WO+BO){1'b0}}};
            mem_wdata = cur_line;
         end
         S_ALLOCATE: begin
            mem_req  = 1'b1;
            mem_addr = {req_tag, req_idx, {(WO+BO){1'b0}}};
         end
         default: ;
      endcase
   end

   // Line status, counters and miss bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid    <= '0;
         dirty    <= '0;
         hit_cnt  <= '0;
         miss_cnt <= '0;
         missed   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (cpu_req) missed <= 1'b0;
            S_COMPARE: begin
               if (hit) begin
                  // The post-refill completion of a miss is not a hit.
                  if (!missed) hit_cnt <= hit_cnt + 16'd1;
                  if (req_we)  dirty[req_idx] <= 1'b1;
               end else begin
                  if (!missed) miss_cnt <= miss_cnt + 16'd1;
                  missed <= 1'b1;
               end
            end
            S_ALLOCATE: begin
               if (mem_ack) begin
                  valid[req_idx] <= 1'b1;
                  dirty[req_idx] <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Request latch and tag/data arrays: no reset, contents are qualified by valid
   always_ff @(posedge clk) begin
      if (state == S_IDLE && cpu_req) begin
         req_addr  <= cpu_addr;
         req_we    <= cpu_we;
         req_wdata <= cpu_wdata;
      end
      if (state == S_ALLOCATE && mem_ack) begin
         tag_arr[req_idx]  <= req_tag;
         data_arr[req_idx] <= mem_rdata;
      end else if (state == S_COMPARE && hit && req_we) begin
         data_arr[req_idx][req_word*DATA_W +: DATA_W] <= req_wdata;
      end
   end
endmodule

// File: tb/tb_cache_ctrl_wb.sv
// tb/tb_cache_ctrl_wb.sv - self-checking bench for cache_ctrl_wb with a behavioural cache model
module tb_cache_ctrl_wb;
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         cpu_req = 1'b0;
   logic         cpu_we = 1'b0;
   logic [31:0]  cpu_addr = '0;
   logic [31:0]  cpu_wdata = '0;
   logic [31:0]  cpu_rdata;
   logic         cpu_ready;
   logic         mem_req;
   logic         mem_we;
   logic [31:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata = '0;
   logic         mem_ack = 1'b0;
   logic [15:0]  hit_cnt;
   logic [15:0]  miss_cnt;

   cache_ctrl_wb dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Behavioural model: backing memory plus a direct-mapped line table
   logic [127:0] bmem [logic [31:0]];
   bit           m_valid [16];
   bit           m_dirty [16];
   logic [23:0]  m_tag   [16];
   logic [127:0] m_data  [16];
   logic [15:0]  exp_hits = '0;
   logic [15:0]  exp_misses = '0;

   // Expectations for the access in flight (written by the driver only)
   int           acc_id = 0;
   bit           exp_wb, exp_rf, exp_we;
   logic [31:0]  exp_wb_addr, exp_rf_addr, exp_rdata;
   logic [127:0] exp_wb_data, exp_rf_line;
   int           exp_n;
   int           last_n;

   // Observations (written by the compare process only)
   int           cyc = 0;
   int           seen_id = 0;
   bit           wb_left = 0, rf_left = 0, rdy_left = 0;
   logic [31:0]  last_wb_addr = '0, last_rf_addr = '0, last_rdata = '0;
   logic [127:0] last_wb_data = '0;
   int           ready_cyc [$];

   function automatic logic [127:0] mem_line(input logic [31:0] la);
      logic [127:0] l;
      if (bmem.exists(la)) return bmem[la];
      for (int i = 0; i < 4; i++) l[i*32 +: 32] = (la + 32'(i * 4)) ^ 32'h5A5A_0000;
      return l;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 0;
         m_dirty[i] = 0;
      end
      exp_hits = '0;
      exp_misses = '0;
   endtask

   task automatic predict(input logic we, input logic [31:0] addr, input logic [31:0] wd, input int lat);
      int          idx;
      int          w;
      logic [23:0] tag;
      logic [31:0] la;
      idx = int'(addr[7:4]);
      w   = int'(addr[3:2]);
      tag = addr[31:8];
      la  = {addr[31:4], 4'h0};
      exp_we = we;
      exp_wb = 0;
      exp_rf = 0;
      exp_n  = 1;
      if (m_valid[idx] && m_tag[idx] == tag) begin
         exp_hits++;
      end else begin
         exp_misses++;
         if (m_valid[idx] && m_dirty[idx]) begin
            exp_wb      = 1;
            exp_wb_addr = {m_tag[idx], addr[7:4], 4'h0};
            exp_wb_data = m_data[idx];
            bmem[exp_wb_addr] = m_data[idx];
            exp_n += lat + 1;
         end
         exp_rf      = 1;
         exp_rf_addr = la;
         exp_rf_line = mem_line(la);
         m_valid[idx] = 1;
         m_dirty[idx] = 0;
         m_tag[idx]   = tag;
         m_data[idx]  = exp_rf_line;
         exp_n += lat + 2;
      end
      exp_rdata = m_data[idx][w*32 +: 32];
      if (we) begin
         m_data[idx][w*32 +: 32] = wd;
         m_dirty[idx] = 1;
      end
      acc_id++;
   endtask

   // One access: called just after a rising edge with the DUT in IDLE; returns the same way.
   task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input int lat, input bit keep);
      int n;
      int wcnt;
      bit done;
      cpu_req = 1'b1;
      cpu_we = we;
      cpu_addr = addr;
      cpu_wdata = wd;
      predict(we, addr, wd, lat);
      n = 0;
      wcnt = 0;
      done = 0;
      while (!done && n < 64) begin
         @(negedge clk);
         if (cpu_ready) done = 1;
         @(posedge clk);
         #1;
         mem_ack = 1'b0;
         if (done) begin
            if (!keep) cpu_req = 1'b0;
         end else begin
            n++;
            if (mem_req) begin
               if (wcnt == lat) begin
                  mem_ack = 1'b1;
                  mem_rdata = mem_we ? {$urandom, $urandom, $urandom, $urandom} : exp_rf_line;
                  wcnt = 0;
               end else begin
                  wcnt++;
               end
            end
         end
      end
      if (!done) cpu_req = 1'b0;
      check("access_completes", done, 1'b1);
      last_n = n;
      check("latency", n, exp_n);
      check("hit_cnt", hit_cnt, exp_hits);
      check("miss_cnt", miss_cnt, exp_misses);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cpu_req = 1'b0;
      mem_ack = 1'b0;
      clear_model();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Compare process: checks DUT outputs against the expectations every cycle
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            check("rst_cpu_ready", cpu_ready, 1'b0);
            check("rst_mem_req", mem_req, 1'b0);
            check("rst_mem_we", mem_we, 1'b0);
            check("rst_cpu_rdata", cpu_rdata, 32'h0);
            check("rst_mem_addr", mem_addr, 32'h0);
            check("rst_mem_wdata", mem_wdata, 128'h0);
            check("rst_hit_cnt", hit_cnt, 16'h0);
            check("rst_miss_cnt", miss_cnt, 16'h0);
            wb_left = 0;
            rf_left = 0;
            rdy_left = 0;
            seen_id = acc_id;
         end else begin
            if (acc_id != seen_id) begin
               seen_id = acc_id;
               wb_left = exp_wb;
               rf_left = exp_rf;
               rdy_left = 1;
            end
            if (!wb_left && !rf_left) begin
               check("mem_req_quiet", mem_req, 1'b0);
            end else if (mem_req) begin
               if (wb_left) begin
                  check("wb_mem_we", mem_we, 1'b1);
                  check("wb_mem_addr", mem_addr, exp_wb_addr);
                  check("wb_mem_wdata", mem_wdata, exp_wb_data);
                  if (mem_ack) begin
                     last_wb_addr = mem_addr;
                     last_wb_data = mem_wdata;
                     wb_left = 0;
                  end
               end else begin
                  check("rf_mem_we", mem_we, 1'b0);
                  check("rf_mem_addr", mem_addr, exp_rf_addr);
                  if (mem_ack) begin
                     last_rf_addr = mem_addr;
                     rf_left = 0;
                  end
               end
            end
            if (!rdy_left || wb_left || rf_left) begin
               check("cpu_ready_quiet", cpu_ready, 1'b0);
            end else if (cpu_ready) begin
               if (!exp_we) check("cpu_rdata", cpu_rdata, exp_rdata);
               last_rdata = cpu_rdata;
               ready_cyc.push_back(cyc);
               rdy_left = 0;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, tests_failed=%0d", tests_failed);
      $fatal(1);
   end

   initial begin
      logic [31:0] a;
      int          k;
      bmem[32'h100] = {32'hD, 32'hC, 32'hB, 32'hA};
      clear_model();
      #1;
      do_reset();

      // 1: cold miss after reset
      access(1'b0, 32'h104, 32'h0, 3, 1'b0);
      check("t1_rf_addr", last_rf_addr, 32'h100);
      check("t1_rdata", last_rdata, 32'hB);
      check("t1_miss_cnt", miss_cnt, 16'd1);
      check("t1_hit_cnt", hit_cnt, 16'd0);

      // 2: load hit
      access(1'b0, 32'h104, 32'h0, 0, 1'b0);
      check("t2_rdata", last_rdata, 32'hB);
      check("t2_latency", last_n, 1);
      check("t2_hit_cnt", hit_cnt, 16'd1);

      // 3: store hit, then dirty conflict
      access(1'b1, 32'h108, 32'h55, 0, 1'b0);
      access(1'b0, 32'h204, 32'h0, 1, 1'b0);
      check("t3_wb_addr", last_wb_addr, 32'h100);
      check("t3_wb_data", last_wb_data, {32'hD, 32'h55, 32'hB, 32'hA});
      check("t3_rf_addr", last_rf_addr, 32'h200);
      check("t3_miss_cnt", miss_cnt, 16'd2);

      // 4: three hits with cpu_req held high throughout
      access(1'b0, 32'h204, 32'h0, 0, 1'b1);
      access(1'b0, 32'h208, 32'h0, 0, 1'b1);
      access(1'b0, 32'h20C, 32'h0, 0, 1'b0);
      check("t4_gap1", ready_cyc[$] - ready_cyc[$-1], 2);
      check("t4_gap2", ready_cyc[$-1] - ready_cyc[$-2], 2);

      // Randomised mix over a few conflicting lines
      for (int i = 0; i < 250; i++) begin
         a = {22'h0, 2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), 2'h0,
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
         access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), 1'b0);
      end

      // Zero-wait miss timings: clean in 4 cycles, dirty in 5 (request cycle included)
      access(1'b1, 32'h7F0, 32'h1234, 0, 1'b0);
      access(1'b0, 32'h8F0, 32'h0, 0, 1'b0);
      check("zw_dirty_latency", last_n + 1, 5);
      do_reset();
      access(1'b0, 32'h8F0, 32'h0, 0, 1'b0);
      check("zw_clean_latency", last_n + 1, 4);

      // 5: reset while a refill is outstanding
      do_reset();
      cpu_req = 1'b1;
      cpu_we = 1'b0;
      cpu_addr = 32'h440;
      predict(1'b0, 32'h440, 32'h0, 0);
      k = 0;
      while (!mem_req && k < 10) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("t5_mem_req_seen", mem_req, 1'b1);
      check("t5_mem_we", mem_we, 1'b0);
      rst = 1'b1;
      #1;
      check("t5_req_drop", mem_req, 1'b0);
      cpu_req = 1'b0;
      clear_model();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      access(1'b0, 32'h440, 32'h0, 1, 1'b0);
      check("t5_miss_again", miss_cnt, 16'd1);
      check("t5_no_hit", hit_cnt, 16'd0);

      // 6: hit counter wrap, preloaded near the top
      @(negedge clk);
      force dut.hit_cnt = 16'hFFFD;
      #1 release dut.hit_cnt;
      exp_hits = 16'hFFFD;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) access(1'b0, 32'h440, 32'h0, 0, 1'b0);
      check("t6_wrap", hit_cnt, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
